inv_subbytes_seq: RTL and testbench

- Inverse SubBytes stage for the AES-256 decryption datapath. It is the decrypt-side counterpart of the combinational encrypt SubBytes stage.
- Applies the AES inverse S-box to all 16 bytes of a 128-bit state.
- Time-multiplexes LANES inverse S-box instances over 16/LANES cycles to save area.
- Uses a valid/ready handshake on both input and output so the decryption round controller can stall it.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/inv_sbox.sv | 11 +
 rtl/inv_subbytes_seq.sv | 95 +++++++++
 tb/tb_inv_subbytes_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, the inverse-SubBytes FSM state type and the inverse S-box table.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int BYTE_W      = 8;
    localparam int NUM_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup for one byte.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] c
);

    assign c = INV_SBOX[a];

endmodule

// File: rtl/inv_subbytes_seq.sv
// Sequential inverse SubBytes: LANES inverse S-boxes applied over 16/LANES cycles
// to a rotating 128-bit shift register, with valid/ready on both sides.
module inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] isb,
    output logic                   busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid and payload stable until then, and ready never depends on valid.

    localparam int STEPS  = NUM_BYTES / LANES;
    localparam int CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int LANE_W = BYTE_W * LANES;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [AES_BLOCK_W-1:0] sreg_q;
    logic [AES_BLOCK_W-1:0] sreg_rot;
    logic [LANE_W-1:0]      sub;
    logic                   last_step;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox u_inv_sbox (
            .a (sreg_q[AES_BLOCK_W-1-BYTE_W*g -: BYTE_W]),
            .c (sub[LANE_W-1-BYTE_W*g -: BYTE_W])
        );
    end

    // Substituted top bytes re-enter at the bottom, so 16/LANES steps restore byte order.
    if (LANES == NUM_BYTES) begin : g_full
        assign sreg_rot = sub;
    end else begin : g_rot
        assign sreg_rot = {sreg_q[AES_BLOCK_W-LANE_W-1:0], sub};
    end

    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                sreg_q <= data;
                cnt_q  <= '0;
            end else if (state_q == RUN) begin
                sreg_q <= sreg_rot;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign isb = out_valid ? sreg_q : '0;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Self-checking bench for inv_subbytes_seq against a GF(2^8)-derived inverse S-box model.
module tb_inv_subbytes_seq;

    localparam int LANES = 4;
    localparam int STEPS = 16 / LANES;
    localparam int N_RAND = 1000;
    localparam logic [127:0] ID_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] ID_OUT = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] data, isb;

    logic         sw_valid;
    logic [127:0] sw_data;
    logic [3:0]   sw_ready, sw_ov, sw_busy;
    logic [127:0] sw_isb [4];

    int           checks = 0;
    int           failures = 0;
    logic [7:0]   inv_tab [256];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    inv_subbytes_seq #(.LANES(LANES)) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready), .data (data),
        .out_valid (out_valid), .out_ready (out_ready), .isb (isb), .busy (busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        inv_subbytes_seq #(.LANES((g < 2) ? (1 << g) : (1 << (g + 1)))) u_sw (
            .clk (clk), .rst (rst), .in_valid (sw_valid), .in_ready (sw_ready[g]), .data (sw_data),
            .out_valid (sw_ov[g]), .out_ready (1'b1), .isb (sw_isb[g]), .busy (sw_busy[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] v);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, v);
        if (v == 8'h00) inv = 8'h00;
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] enc_state(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_fwd(v[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] dec_model(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[v[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- driver / checking tasks ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block with out_ready high; lat counts edges from the launching edge.
    task automatic do_block(input logic [127:0] d, output logic [127:0] res,
                            output int lat, output int hi);
        in_valid = 1'b1;
        data     = d;
        tick();
        lat      = 1;
        in_valid = 1'b0;
        data     = rand128();
        while (!out_valid && lat < 40) begin
            check("run_isb_zero", isb, 128'h0);
            check("run_flags", {in_ready, busy}, 2'b01);
            tick();
            lat++;
        end
        check("block_out_valid", out_valid, 1'b1);
        res = isb;
        hi  = 0;
        while (out_valid && hi < 40) begin
            hi++;
            tick();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] res, held, x, y, cur_x;
        logic [127:0] cin [3];
        logic [127:0] cout [3];
        int           lat, hi, sent, got, cyc;
        logic         acc, dlv, stable;
        int           first [4];
        logic [127:0] sres [4];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data = '0;
        sw_valid = 1'b0; sw_data = '0;
        for (int i = 0; i < 256; i++) inv_tab[sbox_fwd(8'(i))] = 8'(i);

        tick(); tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_isb", isb, 128'h0);
        rst = 1'b0;
        tick();

        // Identity vector
        do_block(ID_IN, res, lat, hi);
        check("id_isb", res, ID_OUT);
        check("id_latency", lat, 1 + STEPS);
        check("id_valid_cycles", hi, 1);
        check("id_isb_after", isb, 128'h0);

        // Constant vectors
        cin[0]  = {16{8'h63}}; cout[0] = {16{8'h00}};
        cin[1]  = {16{8'h00}}; cout[1] = {16{8'h52}};
        cin[2]  = {16{8'hed}}; cout[2] = {16{8'h53}};
        for (int i = 0; i < 3; i++) begin
            do_block(cin[i], res, lat, hi);
            check("const_isb", res, cout[i]);
        end

        // Reset together with in_valid: nothing captured
        in_valid = 1'b1; data = rand128(); rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rstvalid_busy", busy, 1'b0);
        tick();
        check("rstvalid_still_idle", {busy, in_ready}, 2'b01);

        // Backpressure in DONE with a competing request
        x = rand128(); y = rand128();
        out_ready = 1'b0;
        in_valid = 1'b1; data = enc_state(x);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        held = isb;
        check("bp_isb", held, x);
        in_valid = 1'b1; data = enc_state(y);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (isb !== held || {out_valid, in_ready, busy} !== 3'b101) stable = 1'b0;
            tick();
        end
        check("bp_stable", stable, 1'b1);
        out_ready = 1'b1;
        tick();
        check("bp_not_captured", {in_ready, busy}, 2'b10);
        tick();
        in_valid = 1'b0;
        check("bp_captured_after", busy, 1'b1);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        check("bp_second_isb", isb, y);
        tick();

        // Reset abort at cnt=2
        x = rand128();
        in_valid = 1'b1; data = enc_state(x);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_idle", {in_ready, out_valid, busy}, 3'b100);
        check("abort_isb", isb, 128'h0);
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
            tick();
        end
        check("abort_no_output", stable, 1'b1);
        x = rand128();
        do_block(enc_state(x), res, lat, hi);
        check("abort_next_block", res, x);

        // Random round trip, back-to-back requests, random backpressure
        sent = 0; got = 0; cyc = 0;
        cur_x = rand128();
        in_valid = 1'b1; data = enc_state(cur_x);
        while (got < N_RAND && cyc < 40000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("stream_in_ready", in_ready, exp_q.size() == 0);
            check("stream_busy", busy, exp_q.size() != 0);
            if (!out_valid) check("stream_isb_zero", isb, 128'h0);
            else if (exp_q.size() == 0) check("stream_spurious", out_valid, 1'b0);
            else check("stream_isb", isb, exp_q[0]);
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            tick();
            if (dlv && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                got++;
            end
            if (acc) begin
                exp_q.push_back(cur_x);
                sent++;
                if (sent < N_RAND) begin
                    cur_x = rand128();
                    data  = enc_state(cur_x);
                end else begin
                    in_valid = 1'b0;
                end
            end
            cyc++;
        end
        check("stream_count", got, N_RAND);
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();

        // LANES sweep with the identity vector
        for (int g = 0; g < 4; g++) begin
            first[g] = 0;
            sres[g]  = '0;
        end
        sw_data = ID_IN; sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            for (int g = 0; g < 4; g++) begin
                if (sw_ov[g] && first[g] == 0) begin
                    first[g] = c;
                    sres[g]  = sw_isb[g];
                end
            end
            tick();
        end
        for (int g = 0; g < 4; g++) begin
            int lanes;
            lanes = (g < 2) ? (1 << g) : (1 << (g + 1));
            check($sformatf("sweep_lat_l%0d", lanes), first[g], 1 + 16 / lanes);
            check($sformatf("sweep_isb_l%0d", lanes), sres[g], ID_OUT);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
